// File: rtl/vga_pkg.sv
// Shared VGA timing types and 640x480@60 defaults for the raster generator and renderer.
package vga_pkg;

    localparam int unsigned DEF_PIX_DIV = 4;
    localparam int unsigned DEF_H_VIS   = 640;
    localparam int unsigned DEF_H_FP    = 16;
    localparam int unsigned DEF_H_SYNC  = 96;
    localparam int unsigned DEF_H_BP    = 48;
    localparam int unsigned DEF_V_VIS   = 480;
    localparam int unsigned DEF_V_FP    = 10;
    localparam int unsigned DEF_V_SYNC  = 2;
    localparam int unsigned DEF_V_BP    = 33;

    localparam int unsigned CNT_W = 10;

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [11:0]      rgb12_t;

    typedef struct packed {
        int unsigned vis;
        int unsigned fp;
        int unsigned sync;
        int unsigned bp;
    } vga_timing_t;

    function automatic int unsigned timing_total(input vga_timing_t t);
        return t.vis + t.fp + t.sync + t.bp;
    endfunction

endpackage

// File: rtl/vga_pix_div.sv
// Pixel-rate enable: one-clk strobe every PIX_DIV system clocks (constant 1 when PIX_DIV=1).
module vga_pix_div #(
    parameter int unsigned PIX_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic pix_en
);

    localparam int unsigned    DIV_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

    logic [DIV_W-1:0] r_div;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_div <= '0;
        else if (r_div == DIV_LAST)
            r_div <= '0;
        else
            r_div <= r_div + 1'b1;
    end

    assign pix_en = (r_div == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster counters, sync/visible decode and colour blanking.
// Optional `VGA_PIPE_ALIGN_EN registers rgb_out and delays the syncs one pixel period.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned PIX_DIV = DEF_PIX_DIV,
    parameter int unsigned H_VIS   = DEF_H_VIS,
    parameter int unsigned H_FP    = DEF_H_FP,
    parameter int unsigned H_SYNC  = DEF_H_SYNC,
    parameter int unsigned H_BP    = DEF_H_BP,
    parameter int unsigned V_VIS   = DEF_V_VIS,
    parameter int unsigned V_FP    = DEF_V_FP,
    parameter int unsigned V_SYNC  = DEF_V_SYNC,
    parameter int unsigned V_BP    = DEF_V_BP
) (
    input  logic       clk,
    input  logic       reset,
    input  rgb12_t     rgb_in,
    output logic       pix_en,
    output cnt_t       hori_cnt,
    output cnt_t       vert_cnt,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start,
    output rgb12_t     rgb_out
);

    localparam vga_timing_t H_T = '{vis: H_VIS, fp: H_FP, sync: H_SYNC, bp: H_BP};
    localparam vga_timing_t V_T = '{vis: V_VIS, fp: V_FP, sync: V_SYNC, bp: V_BP};
    localparam int unsigned H_TOTAL = timing_total(H_T);
    localparam int unsigned V_TOTAL = timing_total(V_T);

    localparam cnt_t H_LAST   = cnt_t'(H_TOTAL - 1);
    localparam cnt_t V_LAST   = cnt_t'(V_TOTAL - 1);
    localparam cnt_t H_VIS_C  = cnt_t'(H_VIS);
    localparam cnt_t V_VIS_C  = cnt_t'(V_VIS);
    localparam cnt_t HS_FIRST = cnt_t'(H_VIS + H_FP);
    localparam cnt_t HS_LAST  = cnt_t'(H_VIS + H_FP + H_SYNC - 1);
    localparam cnt_t VS_FIRST = cnt_t'(V_VIS + V_FP);
    localparam cnt_t VS_LAST  = cnt_t'(V_VIS + V_FP + V_SYNC - 1);

    logic w_pix_en;
    logic w_h_wrap;
    logic w_v_wrap;
    cnt_t w_hnext;
    cnt_t w_vnext;

    cnt_t r_hcnt;
    cnt_t r_vcnt;
    logic r_video;
    logic r_hsync;
    logic r_vsync;
    logic r_frame;

    vga_pix_div #(
        .PIX_DIV (PIX_DIV)
    ) u_pix_div (
        .clk    (clk),
        .reset  (reset),
        .pix_en (w_pix_en)
    );

    assign w_h_wrap = w_pix_en && (r_hcnt == H_LAST);
    assign w_v_wrap = w_h_wrap && (r_vcnt == V_LAST);

    always_comb begin
        w_hnext = r_hcnt;
        w_vnext = r_vcnt;
        if (w_pix_en)
            w_hnext = w_h_wrap ? '0 : r_hcnt + 1'b1;
        if (w_h_wrap)
            w_vnext = w_v_wrap ? '0 : r_vcnt + 1'b1;
    end

    // Decode is taken from the next counter value so it lands on the same edge as the counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hcnt  <= H_LAST;
            r_vcnt  <= V_LAST;
            r_video <= 1'b0;
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
            r_frame <= 1'b0;
        end else begin
            r_hcnt  <= w_hnext;
            r_vcnt  <= w_vnext;
            r_video <= (w_hnext < H_VIS_C) && (w_vnext < V_VIS_C);
            r_hsync <= !((w_hnext >= HS_FIRST) && (w_hnext <= HS_LAST));
            r_vsync <= !((w_vnext >= VS_FIRST) && (w_vnext <= VS_LAST));
            r_frame <= w_v_wrap;
        end
    end

    assign pix_en      = w_pix_en;
    assign hori_cnt    = r_hcnt;
    assign vert_cnt    = r_vcnt;
    assign frame_start = r_frame;

`ifdef VGA_PIPE_ALIGN_EN
    logic   r_video_d;
    logic   r_hsync_d;
    logic   r_vsync_d;
    rgb12_t r_rgb;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_video_d <= 1'b0;
            r_hsync_d <= 1'b1;
            r_vsync_d <= 1'b1;
            r_rgb     <= '0;
        end else if (w_pix_en) begin
            r_video_d <= r_video;
            r_hsync_d <= r_hsync;
            r_vsync_d <= r_vsync;
            r_rgb     <= r_video ? rgb_in : '0;
        end
    end

    assign video_on = r_video_d;
    assign hsync    = r_hsync_d;
    assign vsync    = r_vsync_d;
    assign rgb_out  = r_rgb;
`else
    assign video_on = r_video;
    assign hsync    = r_hsync;
    assign vsync    = r_vsync;
    assign rgb_out  = r_video ? rgb_in : '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size timing instance for line checks, narrow-line PIX_DIV=1 instance for frame checks.
module tb_vga_timing_gen;

    logic        clk = 1'b0;
    logic        rst_a;
    logic        rst_b;
    logic [11:0] rgb_in;

    logic        a_pix_en, a_video_on, a_hsync, a_vsync, a_fs;
    logic [9:0]  a_hcnt, a_vcnt;
    logic [11:0] a_rgb;

    logic        b_pix_en, b_video_on, b_hsync, b_vsync, b_fs;
    logic [9:0]  b_hcnt, b_vcnt;
    logic [11:0] b_rgb;

    int unsigned vec_cnt = 0;
    int unsigned err_cnt = 0;

    always #5 clk = ~clk;

    vga_timing_gen u_dut_a (
        .clk         (clk),
        .reset       (rst_a),
        .rgb_in      (rgb_in),
        .pix_en      (a_pix_en),
        .hori_cnt    (a_hcnt),
        .vert_cnt    (a_vcnt),
        .video_on    (a_video_on),
        .hsync       (a_hsync),
        .vsync       (a_vsync),
        .frame_start (a_fs),
        .rgb_out     (a_rgb)
    );

    vga_timing_gen #(
        .PIX_DIV (1),
        .H_VIS   (16),
        .H_FP    (2),
        .H_SYNC  (4),
        .H_BP    (3)
    ) u_dut_b (
        .clk         (clk),
        .reset       (rst_b),
        .rgb_in      (rgb_in),
        .pix_en      (b_pix_en),
        .hori_cnt    (b_hcnt),
        .vert_cnt    (b_vcnt),
        .video_on    (b_video_on),
        .hsync       (b_hsync),
        .vsync       (b_vsync),
        .frame_start (b_fs),
        .rgb_out     (b_rgb)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset_a(input string p);
        check_val({p, "_hcnt"},  a_hcnt, 32'd799);
        check_val({p, "_vcnt"},  a_vcnt, 32'd524);
        check_val({p, "_hsync"}, a_hsync, 32'd1);
        check_val({p, "_vsync"}, a_vsync, 32'd1);
        check_val({p, "_video"}, a_video_on, 32'd0);
        check_val({p, "_fs"},    a_fs, 32'd0);
        check_val({p, "_rgb"},   a_rgb, 32'h000);
        check_val({p, "_pix"},   a_pix_en, 32'd0);
    endtask

    task automatic check_reset_b(input string p);
        check_val({p, "_hcnt"},  b_hcnt, 32'd24);
        check_val({p, "_vcnt"},  b_vcnt, 32'd524);
        check_val({p, "_hsync"}, b_hsync, 32'd1);
        check_val({p, "_vsync"}, b_vsync, 32'd1);
        check_val({p, "_video"}, b_video_on, 32'd0);
        check_val({p, "_fs"},    b_fs, 32'd0);
        check_val({p, "_rgb"},   b_rgb, 32'h000);
        check_val({p, "_pix"},   b_pix_en, 32'd1);
    endtask

    // Release A at a falling edge; ends on cycle 5, where the counters first read (0,0).
    task automatic release_a(input string p);
        rst_a = 1'b0;
        check_val({p, "_c1_pix"}, a_pix_en, 32'd0);
        step(1);
        check_val({p, "_c2_pix"}, a_pix_en, 32'd0);
        step(1);
        check_val({p, "_c3_pix"}, a_pix_en, 32'd0);
        step(1);
        check_val({p, "_c4_pix"}, a_pix_en, 32'd1);
        check_val({p, "_c4_hcnt"}, a_hcnt, 32'd799);
        check_val({p, "_c4_fs"}, a_fs, 32'd0);
        step(1);
        check_val({p, "_c5_hcnt"}, a_hcnt, 32'd0);
        check_val({p, "_c5_vcnt"}, a_vcnt, 32'd0);
        check_val({p, "_c5_fs"}, a_fs, 32'd1);
        check_val({p, "_c5_hsync"}, a_hsync, 32'd1);
        check_val({p, "_c5_vsync"}, a_vsync, 32'd1);
        check_val({p, "_c5_video"}, a_video_on, 32'd1);
        check_val({p, "_c5_rgb"}, a_rgb, 32'hF0F);
    endtask

    initial begin
        int hs_low, hs_min, hs_max, vid_on, vid_off_first, pix_cnt, fs_cnt;
        int vs_low, vs_min, vs_max, pix_low, saw_last;
        logic [11:0] rgb_639, rgb_640, rgb_0_480, rgb_0_479;

        rst_a  = 1'b1;
        rst_b  = 1'b1;
        rgb_in = 12'hF0F;
        step(3);
        check_reset_a("a_rst");
        check_reset_b("b_rst");

        release_a("a_start");

        // One full line from (0,0): 3200 clk.
        hs_low = 0; hs_min = 1023; hs_max = 0; vid_on = 0; vid_off_first = 1023;
        pix_cnt = 0; fs_cnt = 0; rgb_639 = 12'hABC; rgb_640 = 12'hABC;
        for (int i = 0; i < 3200; i++) begin
            if (!a_hsync) begin
                hs_low++;
                if (a_hcnt < hs_min) hs_min = a_hcnt;
                if (a_hcnt > hs_max) hs_max = a_hcnt;
            end
            if (a_video_on) vid_on++;
            else if (vid_off_first == 1023) vid_off_first = a_hcnt;
            if (a_pix_en) pix_cnt++;
            if (a_fs) fs_cnt++;
            if (a_hcnt == 10'd639) rgb_639 = a_rgb;
            if (a_hcnt == 10'd640) rgb_640 = a_rgb;
            step(1);
        end
        check_val("line_hs_low_clk", hs_low, 32'd384);
        check_val("line_hs_min", hs_min, 32'd656);
        check_val("line_hs_max", hs_max, 32'd751);
        check_val("line_video_clk", vid_on, 32'd2560);
        check_val("line_video_off_at", vid_off_first, 32'd640);
        check_val("line_pix_en", pix_cnt, 32'd800);
        check_val("line_fs_count", fs_cnt, 32'd1);
        check_val("rgb_639_0", rgb_639, 32'hF0F);
        check_val("rgb_640_0", rgb_640, 32'h000);
        check_val("line_wrap_hcnt", a_hcnt, 32'd0);
        check_val("line_wrap_vcnt", a_vcnt, 32'd1);

        // Asynchronous mid-line reset, then the restart must repeat the first scenario.
        step(300 * 4);
        check_val("a_mid_hcnt", a_hcnt, 32'd300);
        check_val("a_mid_vcnt", a_vcnt, 32'd1);
        #2 rst_a = 1'b1;
        #1 check_reset_a("a_async");
        @(negedge clk);
        release_a("a_restart");

        // Instance B: PIX_DIV=1, 25-pixel lines, full 525-line frame.
        @(negedge clk);
        rst_b = 1'b0;
        step(1);
        check_val("b_start_hcnt", b_hcnt, 32'd0);
        check_val("b_start_vcnt", b_vcnt, 32'd0);
        check_val("b_start_fs", b_fs, 32'd1);

        hs_low = 0; vs_low = 0; vs_min = 1023; vs_max = 0; fs_cnt = 0;
        pix_low = 0; saw_last = 0; rgb_0_480 = 12'hABC; rgb_0_479 = 12'hABC;
        for (int i = 0; i < 25 * 525; i++) begin
            if (!b_hsync) hs_low++;
            if (!b_vsync) begin
                vs_low++;
                if (b_vcnt < vs_min) vs_min = b_vcnt;
                if (b_vcnt > vs_max) vs_max = b_vcnt;
            end
            if (b_fs) fs_cnt++;
            if (!b_pix_en) pix_low++;
            if (b_hcnt == 10'd24 && b_vcnt == 10'd524) saw_last++;
            if (b_hcnt == 10'd0 && b_vcnt == 10'd480) rgb_0_480 = b_rgb;
            if (b_hcnt == 10'd0 && b_vcnt == 10'd479) rgb_0_479 = b_rgb;
            step(1);
        end
        check_val("frame_hs_low_clk", hs_low, 32'd2100);
        check_val("frame_vs_low_clk", vs_low, 32'd50);
        check_val("frame_vs_min", vs_min, 32'd490);
        check_val("frame_vs_max", vs_max, 32'd491);
        check_val("frame_fs_count", fs_cnt, 32'd1);
        check_val("frame_pix_en_low", pix_low, 32'd0);
        check_val("frame_saw_24_524", saw_last, 32'd1);
        check_val("rgb_0_480", rgb_0_480, 32'h000);
        check_val("rgb_0_479", rgb_0_479, 32'hF0F);
        check_val("frame_wrap_hcnt", b_hcnt, 32'd0);
        check_val("frame_wrap_vcnt", b_vcnt, 32'd0);
        check_val("frame_wrap_fs", b_fs, 32'd1);

        // Asynchronous mid-frame reset at (10,200).
        step(200 * 25 + 10);
        check_val("b_mid_hcnt", b_hcnt, 32'd10);
        check_val("b_mid_vcnt", b_vcnt, 32'd200);
        #2 rst_b = 1'b1;
        #1 check_reset_b("b_async");
        @(negedge clk);
        rst_b = 1'b0;
        step(1);
        check_val("b_restart_hcnt", b_hcnt, 32'd0);
        check_val("b_restart_vcnt", b_vcnt, 32'd0);
        check_val("b_restart_fs", b_fs, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
